// File: rtl/reg_file_dbg.sv
// MIPS register file: two registered read ports, one write port, r0 hardwired to zero, debug dump stream.
// Define REG_FILE_BYPASS_EN for write-first reads/captures; otherwise reads are read-first.
module reg_file_dbg #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_regwrite,
    input  logic [ADDR_WIDTH-1:0] i_rd,
    input  logic [DATA_WIDTH-1:0] i_writedata,
    input  logic [ADDR_WIDTH-1:0] i_rs,
    input  logic [ADDR_WIDTH-1:0] i_rt,
    output logic [DATA_WIDTH-1:0] o_regA,
    output logic [DATA_WIDTH-1:0] o_regB,
    input  logic                  i_dump_start,
    input  logic                  i_dump_ready,
    output logic                  o_dump_valid,
    output logic [ADDR_WIDTH-1:0] o_dump_addr,
    output logic [DATA_WIDTH-1:0] o_dump_data,
    output logic                  o_dump_last,
    output logic                  o_dump_done,
    output logic                  o_busy
);

    localparam int unsigned NREGS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } dump_state_t;

    logic [DATA_WIDTH-1:0] regs [NREGS];
    logic                  wr_en;
    dump_state_t           state, state_next;
    logic                  load_first;
    logic                  advance;
    logic [ADDR_WIDTH-1:0] dump_next_addr;

    assign wr_en          = i_regwrite && (i_rd != '0);
    assign dump_next_addr = o_dump_addr + ADDR_WIDTH'(1);

    // Value seen by a read port or the dump capture at this edge.
    function automatic logic [DATA_WIDTH-1:0] port_value(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] v;
        v = regs[a];
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && (a == i_rd)) v = i_writedata;
`endif
        if (a == '0) v = '0;
        return v;
    endfunction

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[i_rd] <= i_writedata;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_regA <= '0;
            o_regB <= '0;
        end else begin
            o_regA <= port_value(i_rs);
            o_regB <= port_value(i_rt);
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next   = state;
        load_first   = 1'b0;
        advance      = 1'b0;
        o_dump_valid = 1'b0;
        o_busy       = 1'b0;
        o_dump_done  = 1'b0;
        case (state)
            IDLE: begin
                if (i_dump_start) begin
                    load_first = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                o_dump_valid = 1'b1;
                o_busy       = 1'b1;
                if (i_dump_ready) begin
                    if (o_dump_addr == LAST_ADDR) state_next = DONE;
                    else                          advance    = 1'b1;
                end
            end
            DONE: begin
                o_busy      = 1'b1;
                o_dump_done = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
        o_dump_last = o_dump_valid && (o_dump_addr == LAST_ADDR);
    end

    // Beat data is captured once on advance and then held, so later writes cannot disturb it.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_dump_addr <= '0;
            o_dump_data <= '0;
        end else if (load_first) begin
            o_dump_addr <= '0;
            o_dump_data <= '0;
        end else if (advance) begin
            o_dump_addr <= dump_next_addr;
            o_dump_data <= port_value(dump_next_addr);
        end
    end

endmodule

// File: tb/tb_reg_file_dbg.sv
// Directed self-checking bench for reg_file_dbg: reset, r0, read/write, collision, dump stream and abort.
module tb_reg_file_dbg;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NREGS = 32;

    logic          i_clock = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_regwrite = 1'b0;
    logic [AW-1:0] i_rd = '0;
    logic [DW-1:0] i_writedata = '0;
    logic [AW-1:0] i_rs = '0;
    logic [AW-1:0] i_rt = '0;
    logic [DW-1:0] o_regA, o_regB;
    logic          i_dump_start = 1'b0;
    logic          i_dump_ready = 1'b0;
    logic          o_dump_valid;
    logic [AW-1:0] o_dump_addr;
    logic [DW-1:0] o_dump_data;
    logic          o_dump_last, o_dump_done, o_busy;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [DW-1:0] model [NREGS];
    logic [DW-1:0] snap  [NREGS];

    reg_file_dbg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_regwrite(i_regwrite), .i_rd(i_rd),
        .i_writedata(i_writedata), .i_rs(i_rs), .i_rt(i_rt), .o_regA(o_regA), .o_regB(o_regB),
        .i_dump_start(i_dump_start), .i_dump_ready(i_dump_ready), .o_dump_valid(o_dump_valid),
        .o_dump_addr(o_dump_addr), .o_dump_data(o_dump_data), .o_dump_last(o_dump_last),
        .o_dump_done(o_dump_done), .o_busy(o_busy)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NREGS; i++) model[i] = '0;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        i_regwrite  = 1'b1;
        i_rd        = AW'(a);
        i_writedata = d;
        @(negedge i_clock);
        i_regwrite  = 1'b0;
        if (a != 0) model[a] = d;
    endtask

    task automatic rd_check(input int a, input int b, input string tag);
        i_rs = AW'(a);
        i_rt = AW'(b);
        @(negedge i_clock);
        check({tag, "_A"}, o_regA, model[a]);
        check({tag, "_B"}, o_regB, model[b]);
    endtask

    // Streams one dump; stalls n_stall cycles on stall_beat, re-pulses start on beat 3,
    // and aborts with reset on abort_at when abort_at >= 0.
    task automatic run_dump(input int stall_beat, input int n_stall, input int abort_at);
        int k, stalls, busy_cnt, done_cnt;
        bit finished;
        k = 0; stalls = 0; busy_cnt = 0; done_cnt = 0; finished = 0;
        for (int i = 0; i < NREGS; i++) snap[i] = model[i];
        i_dump_start = 1'b1;
        i_dump_ready = 1'b1;
        @(negedge i_clock);
        i_dump_start = 1'b0;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            i_regwrite = 1'b0;
            if (o_busy) busy_cnt++;
            if (o_dump_done) done_cnt++;
            if (o_dump_valid) begin
                check("dump_addr", DW'(o_dump_addr), DW'(k));
                check("dump_data", o_dump_data, snap[k]);
                check("dump_last", DW'(o_dump_last), DW'(k == NREGS - 1));
            end
            if (o_dump_valid && k == abort_at) begin
                #2 i_reset = 1'b1;
                #1;
                check("abort_valid", DW'(o_dump_valid), 0);
                check("abort_busy", DW'(o_busy), 0);
                check("abort_addr", DW'(o_dump_addr), 0);
                check("abort_regA", o_regA, 0);
                clear_model();
                @(negedge i_clock);
                i_reset = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    @(negedge i_clock);
                    if (o_dump_done) done_cnt++;
                    check("abort_idle_busy", DW'(o_busy), 0);
                end
                check("abort_no_done", DW'(done_cnt), 0);
                return;
            end
            i_dump_start = o_dump_valid && (k == 3);
            i_dump_ready = 1'b1;
            if (o_dump_valid && k == stall_beat && stalls < n_stall) begin
                i_dump_ready = 1'b0;
                if (stalls == 0) begin
                    i_regwrite  = 1'b1;
                    i_rd        = AW'(k);
                    i_writedata = 32'h0000_0BAD;
                    model[k]    = 32'h0000_0BAD;
                end
                stalls++;
            end
            if (o_dump_valid && i_dump_ready) k++;
            if (done_cnt > 0 && !o_busy) finished = 1;
            else @(negedge i_clock);
        end
        i_dump_start = 1'b0;
        i_regwrite   = 1'b0;
        check("dump_terminated", DW'(finished), 1);
        check("dump_beats", DW'(k), DW'(NREGS));
        check("dump_done_once", DW'(done_cnt), 1);
        check("dump_cycles", DW'(busy_cnt), DW'(NREGS + 1 + n_stall));
    endtask

    initial begin
        clear_model();
        #12;
        check("rst_regA", o_regA, 0);
        check("rst_valid", DW'(o_dump_valid), 0);
        check("rst_busy", DW'(o_busy), 0);
        check("rst_done", DW'(o_dump_done), 0);
        @(negedge i_clock);
        i_reset = 1'b0;
        @(negedge i_clock);

        // Reset clear
        wr(5, 32'hDEAD_BEEF);
        rd_check(5, 5, "pre_rst");
        #2 i_reset = 1'b1;
        #1;
        check("rst_async_A", o_regA, 0);
        check("rst_async_B", o_regB, 0);
        clear_model();
        @(negedge i_clock);
        i_reset = 1'b0;
        rd_check(5, 0, "post_rst");
        check("post_rst_r5", o_regA, 0);

        // r0 hardwired
        wr(0, 32'h1234_5678);
        rd_check(0, 0, "r0");
        check("r0_zero", o_regA, 0);

        // Basic read/write
        wr(7, 32'hA5A5_A5A5);
        wr(31, 32'h0000_FFFF);
        rd_check(7, 31, "rw");
        check("rw_r7", o_regA, 32'hA5A5_A5A5);
        check("rw_r31", o_regB, 32'h0000_FFFF);

        // Same-edge write/read collision
        wr(3, 32'h1);
        i_rs = AW'(3);
        wr(3, 32'h2);
`ifdef REG_FILE_BYPASS_EN
        check("collide", o_regA, 32'h2);
`else
        check("collide", o_regA, 32'h1);
`endif
        rd_check(3, 7, "after_collide");

        // Dump with backpressure: beat 4 held for 3 cycles, frozen against a write to r4
        for (int n = 1; n < NREGS; n++) wr(n, DW'(n * 32'h11));
        run_dump(4, 2, -1);
        rd_check(4, 31, "post_dump");

        // Dump with ignored restart, then reset abort, then a fresh dump from addr 0
        for (int n = 1; n < NREGS; n++) wr(n, DW'(n * 32'h11));
        run_dump(-1, 0, 10);
        wr(9, 32'h99);
        run_dump(-1, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
